// File: rtl/rv_mem_pkg.sv
// Shared definitions for the RV32I data-memory stage: funct3 encodings and
// the access-size classification used by the store and load paths.
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SIZE_BYTE,
    SIZE_HALF,
    SIZE_WORD,
    SIZE_ILLEGAL
  } accessSize_e;

  function automatic accessSize_e decodeSize(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: decodeSize = SIZE_BYTE;
      F3_H, F3_HU: decodeSize = SIZE_HALF;
      F3_W:        decodeSize = SIZE_WORD;
      default:     decodeSize = SIZE_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword out of a memory word and sign- or
// zero-extends it according to the RV32I load funct3.
module load_align
  import rv_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byteLane,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic signed [7:0]  byteSel;
  logic signed [15:0] halfSel;

  always_comb begin
    byteSel = word[{byteLane, 3'b000} +: 8];
    halfSel = byteLane[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    result = 32'(byteSel);
      F3_H:    result = 32'(halfSel);
      F3_W:    result = word;
      F3_BU:   result = {24'd0, byteSel};
      F3_HU:   result = {16'd0, halfSel};
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/data_mem_stage.sv
// MEM stage: byte-addressable data memory with RV32I loads/stores, writeback
// control pass-through, and sticky capture of illegal accesses.
module data_mem_stage
  import rv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] aluResult_in,
  input  logic [31:0] storeData_in,
  input  logic [2:0]  funct3_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [4:0]  rd_in,
  input  logic        MemtoReg_in,
  input  logic        RegWrite_in,
  output logic [31:0] aluResult,
  output logic [31:0] memData,
  output logic [4:0]  rd,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        fault,
  output logic        fault_sticky,
  output logic [31:0] fault_addr,
  output logic [7:0]  fault_count
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] wordIdx;
  logic [1:0]       byteLane;
  accessSize_e      accSize;
  logic             outOfRange;
  logic             misaligned;
  logic             illegalOp;
  logic             memWrEn;
  logic [3:0]       byteEn;
  logic [31:0]      wrData;
  logic [31:0]      rdWord;
  logic [31:0]      loadResult;

  assign wordIdx  = aluResult_in[IDX_W+1:2];
  assign byteLane = aluResult_in[1:0];
  assign accSize  = decodeSize(funct3_in);

  // Any address bit above the array's byte range makes the access illegal.
  assign outOfRange = (aluResult_in >> (IDX_W + 2)) != 32'd0;

  // Data is replicated across lanes so the byte enables alone place it.
  always_comb begin
    misaligned = 1'b0;
    byteEn     = 4'b0000;
    wrData     = storeData_in;
    case (accSize)
      SIZE_BYTE: begin
        byteEn = 4'b0001 << byteLane;
        wrData = {4{storeData_in[7:0]}};
      end
      SIZE_HALF: begin
        misaligned = byteLane[0];
        byteEn     = byteLane[1] ? 4'b1100 : 4'b0011;
        wrData     = {2{storeData_in[15:0]}};
      end
      SIZE_WORD: begin
        misaligned = |byteLane;
        byteEn     = 4'b1111;
      end
      default: ;
    endcase
  end

  assign illegalOp = (accSize == SIZE_ILLEGAL) || (MemRead_in && MemWrite_in);
  assign fault     = (MemRead_in || MemWrite_in) && (outOfRange || misaligned || illegalOp);
  assign memWrEn   = MemWrite_in && !fault;

  assign rdWord = mem[wordIdx];

  load_align uLoadAlign (
    .word     (rdWord),
    .byteLane (byteLane),
    .funct3   (funct3_in),
    .result   (loadResult)
  );

  assign aluResult = aluResult_in;
  assign rd        = rd_in;
  assign MemtoReg  = MemtoReg_in;
  assign RegWrite  = RegWrite_in && !fault;
  assign memData   = (MemRead_in && !fault) ? loadResult : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
    end else if (memWrEn) begin
      for (int lane = 0; lane < 4; lane++)
        if (byteEn[lane]) mem[wordIdx][8*lane +: 8] <= wrData[8*lane +: 8];
    end
  end

  // Only the first fault records its address; the counter saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_sticky <= 1'b0;
      fault_addr   <= 32'd0;
      fault_count  <= 8'd0;
    end else if (fault) begin
      if (!fault_sticky) begin
        fault_sticky <= 1'b1;
        fault_addr   <= aluResult_in;
      end
      if (fault_count != 8'hFF) fault_count <= fault_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed and randomized checks of data_mem_stage against a byte-array
// reference model of RV32I load/store and fault-capture rules.
module tb_data_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] aluResult_in, storeData_in;
  logic [2:0]  funct3_in;
  logic        MemRead_in, MemWrite_in;
  logic [4:0]  rd_in;
  logic        MemtoReg_in, RegWrite_in;
  logic [31:0] aluResult, memData;
  logic [4:0]  rd;
  logic        MemtoReg, RegWrite, fault, fault_sticky;
  logic [31:0] fault_addr;
  logic [7:0]  fault_count;

  data_mem_stage #(.DEPTH_WORDS(256)) dut (
    .clk          (clk),
    .reset        (reset),
    .aluResult_in (aluResult_in),
    .storeData_in (storeData_in),
    .funct3_in    (funct3_in),
    .MemRead_in   (MemRead_in),
    .MemWrite_in  (MemWrite_in),
    .rd_in        (rd_in),
    .MemtoReg_in  (MemtoReg_in),
    .RegWrite_in  (RegWrite_in),
    .aluResult    (aluResult),
    .memData      (memData),
    .rd           (rd),
    .MemtoReg     (MemtoReg),
    .RegWrite     (RegWrite),
    .fault        (fault),
    .fault_sticky (fault_sticky),
    .fault_addr   (fault_addr),
    .fault_count  (fault_count)
  );

  always #5 clk = ~clk;

  int nAsserts = 0;
  int nFails   = 0;

  // Reference model: 1024 bytes plus fault bookkeeping.
  logic [7:0]  refMem [1024];
  bit          refSticky;
  logic [31:0] refAddr;
  int          refCount;

  logic [31:0] lastMemData;
  logic        lastFault, lastRegWrite;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit refFault(bit r, bit w, logic [2:0] f3, logic [31:0] a);
    if (!(r || w)) return 1'b0;
    if (r && w) return 1'b1;
    if (a >= 32'd1024) return 1'b1;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) return 1'b1;
    if (f3 == 3'd2 && (a % 4 != 0)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] refLoad(logic [2:0] f3, logic [31:0] a);
    logic [7:0] b0, b1, b2, b3;
    b0 = refMem[a[9:0]];
    b1 = refMem[a[9:0] + 10'd1];
    b2 = refMem[a[9:0] + 10'd2];
    b3 = refMem[a[9:0] + 10'd3];
    case (f3)
      3'd0:    return {{24{b0[7]}}, b0};
      3'd1:    return {{16{b1[7]}}, b1, b0};
      3'd2:    return {b3, b2, b1, b0};
      3'd4:    return {24'd0, b0};
      3'd5:    return {16'd0, b1, b0};
      default: return 32'd0;
    endcase
  endfunction

  function automatic void refStore(logic [2:0] f3, logic [31:0] a, logic [31:0] d);
    int n;
    n = (f3 == 3'd2) ? 4 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 1);
    for (int k = 0; k < n; k++) refMem[a[9:0] + 10'(k)] = d[8*k +: 8];
  endfunction

  function automatic void refReset();
    for (int k = 0; k < 1024; k++) refMem[k] = 8'd0;
    refSticky = 1'b0;
    refAddr   = 32'd0;
    refCount  = 0;
  endfunction

  // One access cycle; entered and left at a falling edge.
  task automatic access(input bit rdReq, input bit wrReq, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data, input bit rw);
    bit          expFault;
    logic [31:0] expData;
    MemRead_in   = rdReq;
    MemWrite_in  = wrReq;
    funct3_in    = f3;
    aluResult_in = addr;
    storeData_in = data;
    rd_in        = 5'($urandom);
    MemtoReg_in  = 1'($urandom);
    RegWrite_in  = rw;
    #1;
    expFault = refFault(rdReq, wrReq, f3, addr);
    expData  = (rdReq && !expFault) ? refLoad(f3, addr) : 32'd0;
    check("fault", 32'(fault), 32'(expFault));
    check("RegWrite", 32'(RegWrite), 32'(rw && !expFault));
    check("memData", memData, expData);
    check("passthru", {aluResult ^ addr, 27'(rd ^ rd_in), MemtoReg ^ MemtoReg_in}, 59'd0);
    lastMemData  = memData;
    lastFault    = fault;
    lastRegWrite = RegWrite;
    @(posedge clk);
    if (wrReq && !expFault) refStore(f3, addr, data);
    if (expFault) begin
      if (!refSticky) begin
        refSticky = 1'b1;
        refAddr   = addr;
      end
      if (refCount < 255) refCount++;
    end
    @(negedge clk);
    check("fault_sticky", 32'(fault_sticky), 32'(refSticky));
    check("fault_addr", fault_addr, refAddr);
    check("fault_count", 32'(fault_count), 32'(refCount));
  endtask

  task automatic idle();
    MemRead_in  = 1'b0;
    MemWrite_in = 1'b0;
    RegWrite_in = 1'b0;
  endtask

  logic [2:0] loadF3  [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [2:0] storeF3 [3] = '{3'd0, 3'd1, 3'd2};

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] addr;
    bit          isStore, rq, wq;
    int          kind;

    reset = 1'b1;
    idle();
    aluResult_in = 32'd0;
    storeData_in = 32'd0;
    funct3_in    = 3'd0;
    rd_in        = 5'd0;
    MemtoReg_in  = 1'b0;
    refReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    access(1, 0, 3'd2, 32'h00, 32'h0, 1);
    check("rst_lw0", lastMemData, 32'h0);
    check("rst_cnt", 32'(fault_count), 32'h0);

    access(0, 1, 3'd2, 32'h10, 32'h8081_82F3, 0);
    access(1, 0, 3'd0, 32'h10, 32'h0, 1);
    check("LB_10", lastMemData, 32'hFFFF_FFF3);
    access(1, 0, 3'd4, 32'h13, 32'h0, 1);
    check("LBU_13", lastMemData, 32'h0000_0080);
    access(1, 0, 3'd1, 32'h12, 32'h0, 1);
    check("LH_12", lastMemData, 32'hFFFF_8081);
    access(1, 0, 3'd5, 32'h10, 32'h0, 1);
    check("LHU_10", lastMemData, 32'h0000_82F3);

    access(0, 1, 3'd2, 32'h20, 32'h1122_3344, 0);
    access(0, 1, 3'd0, 32'h21, 32'hFFFF_FFAA, 0);
    access(1, 0, 3'd2, 32'h20, 32'h0, 1);
    check("SB_21", lastMemData, 32'h1122_AA44);
    access(0, 1, 3'd1, 32'h22, 32'h5555_BEEF, 0);
    access(1, 0, 3'd2, 32'h20, 32'h0, 1);
    check("SH_22", lastMemData, 32'hBEEF_AA44);

    access(0, 1, 3'd2, 32'h30, 32'hCAFE_F00D, 0);
    access(0, 1, 3'd2, 32'h31, 32'h1234_5678, 1);
    check("mis_fault", 32'(lastFault), 32'd1);
    check("mis_regwr", 32'(lastRegWrite), 32'd0);
    check("mis_sticky", 32'(fault_sticky), 32'd1);
    check("mis_addr", fault_addr, 32'h31);
    check("mis_cnt", 32'(fault_count), 32'd1);
    access(1, 0, 3'd2, 32'h30, 32'h0, 1);
    check("mis_word30", lastMemData, 32'hCAFE_F00D);

    access(1, 0, 3'd2, 32'h400, 32'h0, 1);
    check("oor_data", lastMemData, 32'h0);
    check("oor_addr", fault_addr, 32'h31);
    check("oor_cnt", 32'(fault_count), 32'd2);
    for (int i = 0; i < 260; i++) access(1, 0, 3'd2, 32'h400 + 32'(4 * i), 32'h0, 0);
    check("sat_cnt", 32'(fault_count), 32'd255);

    // Store and fault presented while reset is asserted.
    reset = 1'b1;
    MemRead_in   = 1'b0;
    MemWrite_in  = 1'b1;
    funct3_in    = 3'd2;
    aluResult_in = 32'h40;
    storeData_in = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    MemRead_in   = 1'b1;
    MemWrite_in  = 1'b0;
    aluResult_in = 32'h999;
    #1;
    check("rst_comb_fault", 32'(fault), 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    refReset();
    idle();
    #1;
    check("rst2_sticky", 32'(fault_sticky), 32'd0);
    check("rst2_addr", fault_addr, 32'd0);
    check("rst2_cnt", 32'(fault_count), 32'd0);
    access(1, 0, 3'd2, 32'h40, 32'h0, 1);
    check("rst2_w40", lastMemData, 32'h0);
    access(1, 0, 3'd2, 32'h10, 32'h0, 1);
    check("rst2_w10", lastMemData, 32'h0);

    for (int i = 0; i < 300; i++) begin
      kind    = int'($urandom_range(0, 9));
      isStore = 1'($urandom_range(0, 1));
      f3      = isStore ? storeF3[$urandom_range(0, 2)] : loadF3[$urandom_range(0, 4)];
      addr    = 32'($urandom_range(0, 255)) << 2;
      if (f3 == 3'd0 || f3 == 3'd4) addr = addr + 32'($urandom_range(0, 3));
      else if (f3 == 3'd1 || f3 == 3'd5) addr = addr + 32'(2 * $urandom_range(0, 1));
      rq = !isStore;
      wq = isStore;
      case (kind)
        0: addr = addr + 32'd1;
        1: addr = addr | (32'd1 << $urandom_range(10, 31));
        2: f3 = (isStore ? 3'd3 : 3'd6) | 3'($urandom_range(0, 1));
        3: begin rq = 1'b1; wq = 1'b1; end
        default: ;
      endcase
      access(rq, wq, f3, addr, $urandom, 1'($urandom));
    end

    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/data_mem_stage.md
# data_mem_stage

Memory-access (MEM) stage of the 5-stage RISC-V pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register (`WBRegister`). It owns a byte-addressable data memory that performs RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) and passes the writeback controls through. It also detects misaligned, out-of-range and illegal accesses, suppresses their side effects, and captures fault information in sticky registers for debug.

## Interface
Parameters:
- `DEPTH_WORDS`, default 256: number of 32-bit memory words. Must be a power of two. Byte range is 0 to DEPTH_WORDS*4-1.

Ports:
- `clk`  input  1: single clock; all state updates on its rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `aluResult_in`  input  32: EX result; the byte address for loads and stores.
- `storeData_in`  input  32: rs2 value to store.
- `funct3_in`  input  3: access size and sign (RV32I encoding).
- `MemRead_in`, `MemWrite_in`  input  1 each: load or store request.
- `rd_in`  input  5; `MemtoReg_in`, `RegWrite_in`  input  1 each: writeback controls.
- `aluResult`  output  32: combinational copy of `aluResult_in`.
- `memData`  output  32: load result, already extended; 0 when not loading.
- `rd`, `MemtoReg`  output: combinational copies of the inputs.
- `RegWrite`  output  1: `RegWrite_in`, forced to 0 on a faulting access.
- `fault`  output  1: combinational; the current access is illegal.
- `fault_sticky`  output  1: registered; set by the first fault.
- `fault_addr`  output  32: registered; address of the first fault.
- `fault_count`  output  8: registered saturating fault counter.

## Operation
- Word index is `aluResult_in[log2(DEPTH_WORDS)+1:2]`. Byte lane is `aluResult_in[1:0]`.
- `fault` is asserted when (`MemRead_in` or `MemWrite_in`) and any of the following holds:
  - Address bits above the memory range are nonzero.
  - A halfword access has `addr[0]=1`.
  - A word access has `addr[1:0]!=0`.
  - `funct3_in` is 011, 110 or 111.
  - `MemRead_in` and `MemWrite_in` are both 1.
- Store byte enables:
  - SB (000): one lane, selected by `addr[1:0]`.
  - SH (001): lanes {1,0} or {3,2}, selected by `addr[1]`.
  - SW (010): all four lanes.
  - Store data is taken from the low bits of `storeData_in` and shifted to the selected lane(s).
- Load extraction from the addressed word:
  - LB (000) and LH (001) sign-extend.
  - LBU (100) and LHU (101) zero-extend.
  - LW (010) returns the word unchanged.
- `memData` is 0 when `MemRead_in=0` or `fault=1`.
- Faulting access:
  - No memory write.
  - `memData=0`.
  - `RegWrite=0`.
  - `rd`, `aluResult` and `MemtoReg` still pass through unchanged.
- Fault capture, on a clock edge with `fault=1`:
  - If `fault_sticky=0`: load `fault_addr` with `aluResult_in` and set `fault_sticky`.
  - Increment `fault_count`, saturating at 255.
  - Later faults leave `fault_addr` unchanged.

## Timing
- Read path is combinational: `memData` reflects array contents as of the start of the cycle, so load latency is 0 cycles into `WBRegister`.
- A store commits at the rising edge of the cycle in which it is presented. A load of the same address in the next cycle returns the new data.
- A store and a load cannot occur in the same cycle: there is one access per cycle, and both requests together are a fault.
- Reset (synchronous, `reset=1` at a rising edge):
  - Every memory word is cleared to 0.
  - `fault_sticky=0`, `fault_addr=0`, `fault_count=0`.
  - Stores presented in the reset cycle are discarded.
- Combinational outputs follow their inputs during reset. `WBRegister`'s own reset covers the downstream state.
- Reset takes priority over a store or fault capture in the same cycle.
- `fault_count` holds at 255 on further faults. It does not wrap.

## Structure
- Shared package `rv_mem_pkg`:
  - funct3 constants: `F3_B=3'b000`, `F3_H=3'b001`, `F3_W=3'b010`, `F3_BU=3'b100`, `F3_HU=3'b101`.
  - An access-size enum.
- Natural sub-module: `load_align`, purely combinational. It takes the word, `addr[1:0]` and funct3, and produces the extended result; the bench can reuse it as a reference model.
- Memory array and fault registers live in the top module. Byte-enable generation is inline.

## Test plan
- Reset, then LW at 0x00 → `memData=0`; `fault=0`; `fault_count=0`.
- SW 0x8081_82F3 at 0x10, then LB at 0x10 → 0xFFFF_FFF3; LBU at 0x13 → 0x0000_0080; LH at 0x12 → 0xFFFF_8081; LHU at 0x10 → 0x0000_82F3.
- SB 0xAA at 0x21 over a word of 0x1122_3344 → LW at 0x20 returns 0x1122_AA44. SH 0xBEEF at 0x22 → 0xBEEF_AA44.
- Misaligned SW at 0x31 with `RegWrite_in=1` →
  - `fault=1`, `RegWrite=0`.
  - Word at 0x30 unchanged.
  - `fault_sticky=1`, `fault_addr=0x31`, `fault_count=1`.
- Then out-of-range LW at 0x400 (DEPTH_WORDS=256) → `memData=0`, `fault_addr` stays 0x31, `fault_count=2`. Then 260 further faults → `fault_count=255`.
- Store asserted in the same cycle as `reset=1` → memory stays 0 and fault registers are 0 afterwards.
